// File: rtl/lsu_split_access.sv
// lsu_split_access: load/store unit between the EX/MEM register and dmem.
// Splits XLEN-boundary-crossing accesses into two sequential beats.
module lsu_split_access #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [ADDR_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [XLEN/8-1:0] dmem_wmask,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_resp,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              busy
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = OW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP,
    S_FAULT
  } state_e;

  state_e            state_q;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   buf_q;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic [XLEN-1:0]   rsp_rdata_q;

  logic [1:0]        size_w;
  logic [OW-1:0]     off_w;
  logic [SW-1:0]     bytes_w;
  logic              split_w;
  logic [ADDR_W-1:0] base_w;
  logic              in0_w;
  logic              in1_w;
  logic [2*NB-1:0]   lanes_w;
  logic [2*XLEN-1:0] wd_w;
  logic [OW+2:0]     sh0_w;
  logic [OW+3:0]     sh1_w;
  logic [XLEN-1:0]   raw_w;
  logic [XLEN-1:0]   ext_w;
  logic              sgn_w;
  logic              misal_w;
  logic              fault_w;

  assign size_w  = funct3_q[1:0];
  assign off_w   = addr_q[OW-1:0];
  assign bytes_w = SW'(1) << size_w;
  assign split_w = (SW'(off_w) + bytes_w) > SW'(NB);
  assign base_w  = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
  assign in0_w   = state_q == S_BEAT0;
  assign in1_w   = state_q == S_BEAT1;
  assign sh0_w   = {off_w, 3'b000};
  assign sh1_w   = {(OW+1)'(NB) - {1'b0, off_w}, 3'b000};
  assign wd_w    = {{XLEN{1'b0}}, wdata_q} << sh0_w;

  // Byte-enable window for the whole access, spread over two beats.
  always_comb begin
    lanes_w = '0;
    case (size_w)
      2'd0:    lanes_w = (2*NB)'(8'h01);
      2'd1:    lanes_w = (2*NB)'(8'h03);
      2'd2:    lanes_w = (2*NB)'(8'h0F);
      default: lanes_w = (2*NB)'(8'hFF);
    endcase
    lanes_w = lanes_w << off_w;
  end

  // Merge beat data into a right-justified value, then extend it.
  always_comb begin
    if (in1_w)
      raw_w = buf_q | (dmem_rdata << sh1_w);
    else
      raw_w = dmem_rdata >> sh0_w;
    case (size_w)
      2'd0:    sgn_w = raw_w[7];
      2'd1:    sgn_w = raw_w[15];
      2'd2:    sgn_w = raw_w[31];
      default: sgn_w = raw_w[XLEN-1];
    endcase
    sgn_w = sgn_w & ~funct3_q[2];
    ext_w = raw_w;
    for (int i = 0; i < XLEN; i++)
      if (i >= (8 << size_w)) ext_w[i] = sgn_w;
  end

  // Alignment check on the incoming request.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    misal_w = 1'b0;
      2'd1:    misal_w = req_addr[0];
      2'd2:    misal_w = |req_addr[1:0];
      default: misal_w = |req_addr[2:0];
    endcase
    fault_w = (ALLOW_MISALIGNED == 0) && misal_w;
    if (XLEN == 32 && req_funct3[1:0] == 2'd3)
      fault_w = 1'b1;
  end

  // Request capture, beat sequencing and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          write_q  <= req_write;
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          if (fault_w) begin
            state_q     <= S_FAULT;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= S_BEAT0;
          end
        end
        S_BEAT0: if (dmem_resp) begin
          buf_q <= raw_w;
          if (split_w) begin
            state_q <= S_BEAT1;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= write_q ? '0 : ext_w;
          end
        end
        S_BEAT1: if (dmem_resp) begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b0;
          rsp_rdata_q <= write_q ? '0 : ext_w;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = state_q == S_IDLE;
  assign busy       = state_q != S_IDLE;
  assign dmem_read  = (in0_w | in1_w) & ~write_q;
  assign dmem_write = (in0_w | in1_w) & write_q;

  assign dmem_address = in0_w ? base_w :
                        in1_w ? base_w + ADDR_W'(NB) : '0;
  assign dmem_wmask   = !write_q ? '0 :
                        in0_w ? lanes_w[NB-1:0] :
                        in1_w ? lanes_w[2*NB-1:NB] : '0;
  assign dmem_wdata   = !write_q ? '0 :
                        in0_w ? wd_w[XLEN-1:0] :
                        in1_w ? wd_w[2*XLEN-1:XLEN] : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_split_access.sv
// tb_lsu_split_access: random and directed checks of lsu_split_access.
// Instance a splits misaligned accesses, instance b faults on them.
module tb_lsu_split_access;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic        rdy_a, rd_a, wr_a, rv_a, rf_a, busy_a;
  logic [31:0] ad_a, wd_a, rdt_a;
  logic [3:0]  wm_a;
  logic        rdy_b, rd_b, wr_b, rv_b, rf_b, busy_b;
  logic [31:0] ad_b, wd_b, rdt_b;
  logic [3:0]  wm_b;

  lsu_split_access #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dmem_address(ad_a), .dmem_read(rd_a), .dmem_write(wr_a),
    .dmem_wmask(wm_a), .dmem_wdata(wd_a),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rsp_valid(rv_a), .rsp_rdata(rdt_a), .rsp_fault(rf_a),
    .busy(busy_a)
  );

  lsu_split_access #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dmem_address(ad_b), .dmem_read(rd_b), .dmem_write(wr_b),
    .dmem_wmask(wm_b), .dmem_wdata(wd_b),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rsp_valid(rv_b), .rsp_rdata(rdt_b), .rsp_fault(rf_b),
    .busy(busy_b)
  );

  logic        rd_m, wr_m, rv_m, rf_m;
  logic [31:0] ad_m, wd_m, rdt_m;
  logic [3:0]  wm_m;
  assign rd_m  = sel ? rd_b  : rd_a;
  assign wr_m  = sel ? wr_b  : wr_a;
  assign rv_m  = sel ? rv_b  : rv_a;
  assign rf_m  = sel ? rf_b  : rf_a;
  assign ad_m  = sel ? ad_b  : ad_a;
  assign wd_m  = sel ? wd_b  : wd_a;
  assign rdt_m = sel ? rdt_b : rdt_a;
  assign wm_m  = sel ? wm_b  : wm_a;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } beat_t;

  beat_t      beats[$];
  logic [7:0] pmem [logic [31:0]];
  int cyc = 0;
  int lat_force = -1;
  int beats_allowed = 1000000;
  int wait_cnt = 0;
  int strobe_cyc = 0;
  int last_resp_cyc = 0;
  int rsp_cnt_a = 0;
  bit active = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rv_a) rsp_cnt_a++;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (pmem.exists(a)) return pmem[a];
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h3C;
  endfunction

  function automatic logic [31:0] mask32(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-addressed memory with random per-beat wait states.
  initial begin
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (!(rd_m || wr_m)) begin
        active = 1'b0;
      end else begin
        strobe_cyc++;
        if (!active) begin
          active = 1'b1;
          if (lat_force >= 0) wait_cnt = lat_force;
          else wait_cnt = int'($urandom_range(0, 2));
        end
        if (wait_cnt == 0 && beats_allowed > 0) begin
          beats_allowed--;
          active = 1'b0;
          beats.push_back('{ad_m, wm_m, wd_m});
          for (int i = 0; i < 4; i++) begin
            if (wr_m && wm_m[i]) pmem[ad_m + 32'(i)] = wd_m[8*i +: 8];
            dmem_rdata[8*i +: 8] = rd_byte(ad_m + 32'(i));
          end
          dmem_resp = 1'b1;
          last_resp_cyc = cyc;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic run_req(input bit sb, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got);
    int nb, n, st, exp_n, idx;
    bit fault;
    longint v;
    logic [31:0] w0, a, w, exp_rd;
    logic [31:0] ex_ad [2];
    logic [3:0]  ex_m  [2];
    logic [31:0] ex_wd [2];
    nb = 1 << f3[1:0];
    fault = (f3[1:0] == 2'd3) || (sb && (addr % nb) != 0);
    exp_n = 0;
    v = 0;
    w0 = {addr[31:2], 2'b00};
    for (int k = 0; k < 2; k++) begin
      ex_ad[k] = '0; ex_m[k] = '0; ex_wd[k] = '0;
    end
    for (int k = 0; k < nb; k++) begin
      a = addr + 32'(k);
      w = {a[31:2], 2'b00};
      idx = (w == w0) ? 0 : 1;
      ex_ad[idx] = w;
      if (wr) begin
        ex_m[idx][a[1:0]] = 1'b1;
        ex_wd[idx][8*a[1:0] +: 8] = wd[8*k +: 8];
      end
      if (idx + 1 > exp_n) exp_n = idx + 1;
      v = v | (longint'(rd_byte(a)) << (8*k));
    end
    if (!f3[2] && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
    exp_rd = (wr || fault) ? 32'h0 : v[31:0];
    if (fault) exp_n = 0;

    beats.delete();
    strobe_cyc = 0;
    @(negedge clk);
    chk("req_ready", sb ? rdy_b : rdy_a, 1);
    sel = sb;
    req_valid = 1'b1;
    req_write = wr;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    st = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rv_m && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", n < 60, 1);
    got = rdt_m;
    chk("rsp_fault", rf_m, fault);
    chk("rsp_rdata", rdt_m, exp_rd);
    if (fault) begin
      chk("fault_lat", cyc - st, 1);
      chk("fault_strobes", strobe_cyc, 0);
    end else begin
      chk("resp_lat", cyc - last_resp_cyc, 1);
    end
    chk("beat_count", beats.size(), exp_n);
    for (int b = 0; b < exp_n && b < beats.size(); b++) begin
      chk("beat_addr", beats[b].addr, ex_ad[b]);
      chk("beat_mask", beats[b].mask, ex_m[b]);
      if (wr)
        chk("beat_wdata", beats[b].wdata & mask32(ex_m[b]), ex_wd[b]);
    end
    @(negedge clk);
    chk("rsp_pulse", rv_m, 0);
    chk("rsp_hold", rdt_m, exp_rd);
    if (wr && !fault)
      for (int k = 0; k < nb; k++)
        chk("mem_byte", rd_byte(addr + 32'(k)), wd[8*k +: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, ad, wd;
    logic [2:0]  f3;
    int n, c0;
    sel = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {rdy_a, rdy_b}, 2'b11);
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_strobes", {rd_a, wr_a, rd_b, wr_b}, 0);
    chk("rst_rsp", {rv_a, rf_a, rv_b, rf_b}, 0);
    chk("rst_rdata", rdt_a, 0);
    chk("rst_addr", ad_a, 0);
    chk("rst_wmask", wm_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    pmem[32'h1000] = 8'hEF; pmem[32'h1001] = 8'hBE;
    pmem[32'h1002] = 8'hAD; pmem[32'h1003] = 8'hDE;
    lat_force = 2;
    run_req(0, 0, 3'b010, 32'h1000, 0, got);
    chk("t1_lw", got, 32'hDEADBEEF);
    lat_force = -1;

    pmem[32'h1000] = 8'h56; pmem[32'h1001] = 8'h34;
    pmem[32'h1002] = 8'h12; pmem[32'h1003] = 8'h80;
    run_req(0, 0, 3'b000, 32'h1003, 0, got);
    chk("t2_lb", got, 32'hFFFFFF80);
    run_req(0, 0, 3'b100, 32'h1003, 0, got);
    chk("t2_lbu", got, 32'h00000080);

    run_req(0, 1, 3'b001, 32'h1002, 32'h0000ABCD, got);
    chk("t3_mask", beats[0].mask, 4'b1100);
    chk("t3_wdata", beats[0].wdata & 32'hFFFF0000, 32'hABCD0000);
    chk("t3_rdata", got, 0);

    pmem[32'h1000] = 8'h88; pmem[32'h1001] = 8'h77;
    pmem[32'h1002] = 8'h66; pmem[32'h1003] = 8'h55;
    pmem[32'h1004] = 8'h44; pmem[32'h1005] = 8'h33;
    pmem[32'h1006] = 8'h22; pmem[32'h1007] = 8'h11;
    run_req(0, 0, 3'b010, 32'h1002, 0, got);
    chk("t4_split_lw", got, 32'h33445566);

    run_req(0, 1, 3'b010, 32'h1003, 32'hAABBCCDD, got);
    chk("t5_b0_addr", beats[0].addr, 32'h1000);
    chk("t5_b0_mask", beats[0].mask, 4'b1000);
    chk("t5_b0_wdata", beats[0].wdata & 32'hFF000000, 32'hDD000000);
    chk("t5_b1_addr", beats[1].addr, 32'h1004);
    chk("t5_b1_mask", beats[1].mask, 4'b0111);
    chk("t5_b1_wdata", beats[1].wdata & 32'h00FFFFFF, 32'h00AABBCC);

    run_req(1, 0, 3'b001, 32'h1001, 0, got);
    chk("t6_fault_rdata", got, 0);
    run_req(0, 0, 3'b010, 32'hFFFFFFFE, 0, got);
    run_req(0, 0, 3'b011, 32'h1000, 0, got);

    beats_allowed = 1;
    lat_force = 0;
    @(negedge clk);
    sel = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h1002;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(rd_a && ad_a == 32'h1004) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_beat1_seen", n < 20, 1);
    c0 = rsp_cnt_a;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", rd_a, 0);
    chk("mid_rst_ready", rdy_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_norsp", rsp_cnt_a - c0, 0);
    beats_allowed = 1000000;
    lat_force = -1;

    for (int t = 0; t < 300; t++) begin
      f3 = 3'($urandom_range(0, 7));
      if (f3[1:0] == 2'd3 && $urandom_range(0, 3) != 0) f3[1:0] = 2'd2;
      if ($urandom_range(0, 15) == 0)
        ad = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else
        ad = 32'h2000 + 32'($urandom_range(0, 63));
      wd = $urandom;
      run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              f3, ad, wd, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
